// File: rtl/wrn_mqueue_pkg.sv
// Shared definitions for the mqueue stream blocks: channel limits, the round-robin mux
// state type and a small width helper.
package wrn_mqueue_pkg;

  localparam int c_mt_stream_max_chan = 16;
  localparam int c_mt_chan_w          = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
    ST_DROP
  } t_rr_mux_state;

  // Index width that stays legal (1 bit) for a single-channel configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mt_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the pointer,
// wrapping modulo g_num_req, and returns it as one-hot and as an index.
module mt_rr_arbiter #(
  parameter int g_num_req = 4,
  parameter int g_idx_w   = 2
) (
  input  logic [g_num_req-1:0] req,
  input  logic [g_idx_w-1:0]   ptr,
  output logic [g_num_req-1:0] gnt_onehot,
  output logic [g_idx_w-1:0]   gnt_idx
);

  function automatic int wrap_idx(input logic [g_idx_w-1:0] p, input int off);
    return (int'(p) + off) % g_num_req;
  endfunction

  logic found;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the loop can leave a value held and infer a latch.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    for (int off = 1; off <= g_num_req; off++) begin
      if (!found && req[wrap_idx(ptr, off)]) begin
        found                          = 1'b1;
        gnt_onehot[wrap_idx(ptr, off)] = 1'b1;
        gnt_idx                        = g_idx_w'(wrap_idx(ptr, off));
      end
    end
  end

endmodule

// File: rtl/mt_stream_rr_mux.sv
// Packet-atomic round-robin mux for MT valid/ready/last streams, with optional
// channel-ID header word and maximum-length truncation of oversize packets.
module mt_stream_rr_mux
  import wrn_mqueue_pkg::*;
#(
  parameter int g_num_inputs    = 4,
  parameter int g_data_width    = 32,
  parameter int g_insert_header = 1,
  parameter int g_max_words     = 256
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [g_num_inputs-1:0]              snk_valid_i,
  input  logic [g_num_inputs-1:0]              snk_last_i,
  input  logic [g_num_inputs*g_data_width-1:0] snk_data_i,
  output logic [g_num_inputs-1:0]              snk_ready_o,
  output logic                                 src_valid_o,
  output logic                                 src_last_o,
  output logic [g_data_width-1:0]              src_data_o,
  output logic [c_mt_chan_w-1:0]               src_chan_o,
  input  logic                                 src_ready_i,
  output logic                                 truncate_o
);

  localparam int c_idx_w = idx_width(g_num_inputs);
  localparam int c_cnt_w = $clog2(g_max_words + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(g_max_words - 1);

  t_rr_mux_state state_q, state_d;

  logic [c_idx_w-1:0]      grant_q, arb_idx;
  logic [g_num_inputs-1:0] arb_onehot;
  logic                    arb_any;
  logic [c_cnt_w-1:0]      cnt_q;

  logic                    slot_free;
  logic                    sel_valid, sel_last;
  logic [g_data_width-1:0] sel_data, hdr_word;

  logic grant_load, load_hdr, load_word, force_last, trunc_set, cnt_inc, cnt_clr;

  mt_rr_arbiter #(
    .g_num_req (g_num_inputs),
    .g_idx_w   (c_idx_w)
  ) u_arb (
    .req        (snk_valid_i),
    .ptr        (grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  assign arb_any   = |arb_onehot;
  assign slot_free = !src_valid_o || src_ready_i;
  assign sel_valid = snk_valid_i[grant_q];
  assign sel_last  = snk_last_i[grant_q];
  assign sel_data  = snk_data_i[grant_q*g_data_width +: g_data_width];

  always_comb begin
    hdr_word                    = '0;
    hdr_word[c_mt_chan_w-1:0]   = c_mt_chan_w'(grant_q);
  end

  always_comb begin
    state_d     = state_q;
    snk_ready_o = '0;
    grant_load  = 1'b0;
    load_hdr    = 1'b0;
    load_word   = 1'b0;
    force_last  = 1'b0;
    trunc_set   = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_load = 1'b1;
          state_d    = (g_insert_header != 0) ? ST_HEAD : ST_DATA;
        end
      end
      ST_HEAD: begin
        if (slot_free) begin
          load_hdr = 1'b1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        snk_ready_o[grant_q] = slot_free;
        if (slot_free && sel_valid) begin
          load_word = 1'b1;
          if (sel_last) begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == c_cnt_last) begin
            // Cutting at equality keeps the counter from ever wrapping.
            force_last = 1'b1;
            trunc_set  = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = ST_DROP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_DROP: begin
        snk_ready_o[grant_q] = 1'b1;
        if (sel_valid && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: data and channel registers are reset as well, so the outputs read as zero
  // after reset rather than as leftovers of an abandoned packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q     <= c_idx_w'(g_num_inputs - 1);
      cnt_q       <= '0;
      src_valid_o <= 1'b0;
      src_last_o  <= 1'b0;
      src_data_o  <= '0;
      src_chan_o  <= '0;
      truncate_o  <= 1'b0;
    end else begin
      truncate_o <= trunc_set;
      if (grant_load) grant_q <= arb_idx;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + c_cnt_w'(1);
      // The output register only changes when its current word has left or was empty.
      if (slot_free) begin
        src_valid_o <= load_hdr || load_word;
        if (load_hdr) begin
          src_data_o <= hdr_word;
          src_last_o <= 1'b0;
          src_chan_o <= c_mt_chan_w'(grant_q);
        end else if (load_word) begin
          src_data_o <= sel_data;
          src_last_o <= sel_last || force_last;
          src_chan_o <= c_mt_chan_w'(grant_q);
        end
      end
    end
  end

endmodule
